// File: rtl/ui_bridge_pkg.sv
// Shared opcodes, response codes and state encoding for the host command bridge.
package ui_bridge_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [BYTE_W-1:0] {
    OP_SET_STEPS = 8'h01,
    OP_RUN       = 8'h02,
    OP_STATUS    = 8'h03,
    OP_UNKNOWN   = 8'hFF
  } opcode_e;

  localparam logic [BYTE_W-1:0] RSP_OK  = 8'hA5;
  localparam logic [BYTE_W-1:0] RSP_REJ = 8'hEE;
  localparam logic [BYTE_W-1:0] RSP_UNK = 8'hEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARG  = 2'd1,
    S_EXEC = 2'd2,
    S_RSP  = 2'd3
  } state_e;

endpackage

// File: rtl/ui_bridge_rsp_serializer.sv
// Up to 4-byte response buffer, shifted out LSB first over a valid/ready handshake.
module rsp_serializer
  import ui_bridge_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic [LEN_W-1:0]  load_len_i,
  input  logic              rsp_ready_i,
  output logic [BYTE_W-1:0] rsp_data_o,
  output logic              rsp_valid_o,
  output logic              last_hs_c
);

  logic [WORD_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              valid_q, valid_d;

  assign last_hs_c   = valid_q && rsp_ready_i && (len_q == LEN_W'(1));
  assign rsp_data_o  = buf_q[BYTE_W-1:0];
  assign rsp_valid_o = valid_q;

  always_comb begin
    buf_d   = buf_q;
    len_d   = len_q;
    valid_d = valid_q;
    if (load_i) begin
      buf_d   = load_data_i;
      len_d   = load_len_i;
      valid_d = 1'b1;
    end else if (valid_q && rsp_ready_i) begin
      if (len_q == LEN_W'(1)) begin
        buf_d   = '0;
        len_d   = '0;
        valid_d = 1'b0;
      end else begin
        buf_d = buf_q >> BYTE_W;
        len_d = len_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      len_q   <= len_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/ui_bridge.sv
// Host byte-command bridge: decodes opcodes, programs the step count, launches runs
// and returns status/acknowledge bytes to the host.
module ui_bridge
  import ui_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [BYTE_W-1:0] rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  input  logic              ui_valid,
  output logic              ui_done,
  output logic [WORD_W-1:0] num_steps,
  input  logic [WORD_W-1:0] cnt_in,
  output logic              busy
);

  state_e            state_q, state_d;
  opcode_e           op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [WORD_W-1:0] snap_q, snap_d;
  logic [WORD_W-1:0] num_steps_q, num_steps_d;
  logic              ui_done_q, ui_done_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;

  logic              accept_c;
  logic              load_c;
  logic [WORD_W-1:0] load_data_c;
  logic [LEN_W-1:0]  load_len_c;
  logic              last_hs_c;

  assign accept_c  = cmd_valid && cmd_ready_q;
  assign cmd_ready = cmd_ready_q;
  assign ui_done   = ui_done_q;
  assign num_steps = num_steps_q;
  assign busy      = busy_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    snap_d      = snap_q;
    num_steps_d = num_steps_q;
    ui_done_d   = 1'b0;
    load_c      = 1'b0;
    load_data_c = '0;
    load_len_c  = LEN_W'(1);

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_EXEC;
          case (cmd_data)
            OP_SET_STEPS: begin
              op_d    = OP_SET_STEPS;
              cnt_d   = '0;
              state_d = S_ARG;
            end
            OP_RUN:    op_d = OP_RUN;
            OP_STATUS: begin
              op_d   = OP_STATUS;
              snap_d = cnt_in;
            end
            default:   op_d = OP_UNKNOWN;
          endcase
        end
      end
      S_ARG: begin
        // Little-endian argument assembly; ui_valid deliberately ignored here.
        if (accept_c) begin
          shadow_d[BYTE_W*cnt_q +: BYTE_W] = cmd_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(3)) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        load_c  = 1'b1;
        state_d = S_RSP;
        case (op_q)
          OP_SET_STEPS: begin
            if (ui_valid) begin
              num_steps_d = shadow_q;
              load_data_c = WORD_W'(RSP_OK);
            end else begin
              load_data_c = WORD_W'(RSP_REJ);
            end
          end
          OP_RUN: begin
            if (ui_valid && (num_steps_q != '0)) begin
              ui_done_d   = 1'b1;
              load_data_c = WORD_W'(RSP_OK);
            end else begin
              load_data_c = WORD_W'(RSP_REJ);
            end
          end
          OP_STATUS: begin
            load_data_c = snap_q;
            load_len_c  = LEN_W'(4);
          end
          default: load_data_c = WORD_W'(RSP_UNK);
        endcase
      end
      S_RSP: begin
        if (last_hs_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_ARG);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_UNKNOWN;
      cnt_q       <= '0;
      shadow_q    <= '0;
      snap_q      <= '0;
      num_steps_q <= WORD_W'(1);
      ui_done_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      snap_q      <= snap_d;
      num_steps_q <= num_steps_d;
      ui_done_q   <= ui_done_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  rsp_serializer u_ser (
    .clk_i       (clk),
    .rst_ni      (rst),
    .load_i      (load_c),
    .load_data_i (load_data_c),
    .load_len_i  (load_len_c),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_valid_o (rsp_valid),
    .last_hs_c   (last_hs_c)
  );

endmodule

// File: tb/tb_ui_bridge.sv
// Directed bench for ui_bridge: command/response sequences with hand-computed results.
module tb_ui_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        ui_valid;
  logic        ui_done;
  logic [31:0] num_steps;
  logic [31:0] cnt_in;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ui_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .ui_valid  (ui_valid),
    .ui_done   (ui_done),
    .num_steps (num_steps),
    .cnt_in    (cnt_in),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("send_timeout", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  // Waits for a response byte, checks it, then handshakes it.
  task automatic recv(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check(tag, {24'd0, rsp_data}, {24'd0, exp});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] status_bytes [4];
    status_bytes[0] = 8'h78; status_bytes[1] = 8'h56;
    status_bytes[2] = 8'h34; status_bytes[3] = 8'h12;

    rst = 1'b0; cmd_data = 8'h00; cmd_valid = 1'b0; rsp_ready = 1'b0;
    ui_valid = 1'b0; cnt_in = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  {24'd0, rsp_data}, 32'd0);
    check("rst_ui_done",   {31'd0, ui_done}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_num_steps", num_steps, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // SET_STEPS 0x10 accepted
    ui_valid = 1'b1;
    send(8'h01); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
    check("set_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("set_exec_busy", {31'd0, busy}, 32'd1);
    check("set_exec_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("set_lat_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("set_num_steps", num_steps, 32'h0000_0010);
    recv("set_ok", 8'hA5);
    check("set_back_idle_busy", {31'd0, busy}, 32'd0);
    check("set_back_idle_rdy", {31'd0, cmd_ready}, 32'd1);
    check("set_back_idle_vld", {31'd0, rsp_valid}, 32'd0);

    // SET_STEPS rejected: ui_valid high during ARG, low in EXEC
    ui_valid = 1'b1;
    send(8'h01); send(8'h05); send(8'h00); send(8'h00);
    ui_valid = 1'b0;
    send(8'h00);
    @(negedge clk);
    recv("set_rej", 8'hEE);
    check("set_rej_num_steps", num_steps, 32'h0000_0010);

    // RUN accepted: ui_done one cycle, 2 cycles after accept
    ui_valid = 1'b1;
    send(8'h02);
    check("run_c1_ui_done", {31'd0, ui_done}, 32'd0);
    check("run_c1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("run_c2_ui_done", {31'd0, ui_done}, 32'd1);
    check("run_c2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("run_c2_rsp_data", {24'd0, rsp_data}, 32'h0000_00A5);
    @(negedge clk);
    check("run_c3_ui_done", {31'd0, ui_done}, 32'd0);
    recv("run_ok", 8'hA5);

    // num_steps = 0 then RUN rejected
    send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    @(negedge clk);
    check("set_zero_num_steps", num_steps, 32'd0);
    recv("set_zero_ok", 8'hA5);
    send(8'h02);
    for (int i = 0; i < 3; i++) begin
      check("run_zero_ui_done", {31'd0, ui_done}, 32'd0);
      @(negedge clk);
    end
    recv("run_zero_rej", 8'hEE);

    // STATUS with snapshot and stalled host
    cnt_in = 32'h1234_5678;
    send(8'h03);
    cnt_in = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("status_valid", {31'd0, rsp_valid}, 32'd1);
      check("status_byte", {24'd0, rsp_data}, {24'd0, status_bytes[i]});
      @(negedge clk);
      check("status_stall_hold", {24'd0, rsp_data}, {24'd0, status_bytes[i]});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    check("status_done_valid", {31'd0, rsp_valid}, 32'd0);
    check("status_done_busy", {31'd0, busy}, 32'd0);

    // Unknown opcode
    send(8'h7F);
    @(negedge clk);
    recv("unknown", 8'hEF);
    check("unknown_single_byte", {31'd0, rsp_valid}, 32'd0);

    // Reset mid SET_STEPS
    send(8'h01); send(8'hAA); send(8'hBB);
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("abort_num_steps", num_steps, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    check("abort_idle_ready", {31'd0, cmd_ready}, 32'd1);
    send(8'h7F);
    @(negedge clk);
    recv("abort_then_unknown", 8'hEF);
    check("abort_final_num_steps", num_steps, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
